// File: rtl/fetch_instruction_if.sv
// Instruction memory bus between fetch (master) and imem (slave).
// imem_req/imem_addr out; imem_data/imem_done/imem_err back.
interface fetch_instruction_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    input  imem_done,
    input  imem_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    output imem_done,
    output imem_err
  );
endinterface

// File: rtl/fetch_instruction.sv
// Fetch stage: owns pc, fetches over imem, holds one word for decode.
// Ports: clk/rst, stall_in, redirect_*, imem bus, instr/pc_plus2/valid/halted/err.
module fetch_instruction #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  fetch_instruction_if.master imem,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FULL,
    DRAIN,
    HALTED
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [15:0] pc;
  logic [15:0] pcNext;
  logic [15:0] redirPc;
  logic        isHalt;
  logic        doRedir;
  logic        doCapture;
  logic        doConsume;

  assign pcNext  = pc + 16'd2;
  assign redirPc = {redirect_pc[15:1], 1'b0};
  assign isHalt  = imem.imem_data[15:11] == HALT_OPCODE;

  // HALTED ignores redirects entirely.
  assign doRedir   = redirect_valid && state != HALTED;
  assign doCapture = state == REQ && imem.imem_done
                     && !redirect_valid;
  assign doConsume = (state == FULL || state == HALTED)
                     && !stall_in && !doRedir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: nextState = REQ;
      REQ: begin
        if (redirect_valid) begin
          nextState = imem.imem_done ? REQ : DRAIN;
        end else if (imem.imem_done) begin
          if (isHalt || imem.imem_err) begin
            nextState = HALTED;
          end else begin
            nextState = FULL;
          end
        end
      end
      FULL: begin
        if (redirect_valid || !stall_in) begin
          nextState = REQ;
        end
      end
      DRAIN: begin
        if (imem.imem_done) begin
          nextState = REQ;
        end
      end
      HALTED: nextState = HALTED;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    if (state == REQ) begin
      imem.imem_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr_out    <= NOP_INSTR;
      pc_plus2_out <= 16'h0000;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
    end else begin
      unique case (1'b1)
        doRedir: begin
          pc          <= redirPc;
          instr_valid <= 1'b0;
          instr_out   <= NOP_INSTR;
          if (redirect_pc[0]) begin
            err <= 1'b1;
          end
        end
        doCapture: begin
          instr_out    <= imem.imem_data;
          pc_plus2_out <= pcNext;
          pc           <= pcNext;
          instr_valid  <= 1'b1;
          if (imem.imem_err) begin
            err <= 1'b1;
          end
          if (isHalt || imem.imem_err) begin
            halted <= 1'b1;
          end
        end
        doConsume: begin
          instr_valid <= 1'b0;
          instr_out   <= NOP_INSTR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_instruction.sv
// Bench for fetch_instruction: directed plan plus random traffic
// against a transaction-level model with a latency-randomized imem.
module tb_fetch_instruction;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        instr_valid;
  logic        halted;
  logic        err;

  fetch_instruction_if bus();

  fetch_instruction dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instr_out      (instr_out),
    .pc_plus2_out   (pc_plus2_out),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .err            (err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  task automatic chk(string name, logic [15:0] act,
                     logic [15:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // memory: one transaction at a time, starts on req, done after lat
  logic [15:0] mem [0:32767];
  int          memLat = 0;
  bit          errOn = 1'b0;
  bit          memBusy = 1'b0;
  int          memCnt = 0;
  logic [15:0] memAddr = 16'h0000;
  bit          rstSeen = 1'b0;

  initial forever begin
    @(posedge clk);
    rstSeen = rst;
  end

  initial begin
    bus.imem_done = 1'b0;
    bus.imem_err  = 1'b0;
    bus.imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      bus.imem_done = 1'b0;
      bus.imem_err  = 1'($urandom_range(0, 1));
      bus.imem_data = 16'($urandom);
      if (rstSeen) memBusy = 1'b0;
      if (!memBusy && bus.imem_req) begin
        memBusy = 1'b1;
        memAddr = bus.imem_addr;
        memCnt  = memLat < 0 ? int'($urandom_range(0, 3)) : memLat;
      end
      if (memBusy) begin
        if (memCnt == 0) begin
          bus.imem_done = 1'b1;
          bus.imem_data = mem[memAddr[15:1]];
          bus.imem_err  = errOn && $urandom_range(0, 79) == 0;
          memBusy = 1'b0;
        end else begin
          memCnt--;
        end
      end
    end
  end

  // model: what is outstanding (live fetch / orphaned fetch / held word)
  logic [15:0] mPc, mWord, mP2;
  bit mValid, mHalt, mErr, mBooted, mFetch, mDead;
  bit modelOn = 1'b0;

  task automatic modelStep();
    logic [15:0] d;
    bit dn;
    d  = bus.imem_data;
    dn = bus.imem_done;
    if (rst) begin
      mPc = 16'h0000; mWord = 16'h0800; mP2 = 16'h0000;
      mValid = 0; mHalt = 0; mErr = 0;
      mBooted = 0; mFetch = 0; mDead = 0;
    end else if (mHalt) begin
      if (!stall_in) begin
        mValid = 0;
        mWord = 16'h0800;
      end
    end else if (redirect_valid) begin
      mPc = redirect_pc & 16'hFFFE;
      if (redirect_pc[0]) mErr = 1;
      mValid = 0;
      mWord = 16'h0800;
      if (mFetch && !dn) begin
        mDead = 1;
        mFetch = 0;
      end else if (!(mDead && !dn)) begin
        mDead = 0;
        mFetch = 1;
      end
    end else if (!mBooted) begin
      mFetch = 1;
    end else if (mFetch && dn) begin
      mWord = d;
      mValid = 1;
      mPc = mPc + 16'd2;
      mP2 = mPc;
      mFetch = 0;
      if (bus.imem_err) begin
        mErr = 1;
        mHalt = 1;
      end
      if (d[15:11] == 5'd0) mHalt = 1;
    end else if (mDead && dn) begin
      mDead = 0;
      mFetch = 1;
    end else if (mValid && !stall_in) begin
      mValid = 0;
      mWord = 16'h0800;
      mFetch = 1;
    end
    if (!rst) mBooted = 1;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (modelOn) begin
      chk("model req", 16'(bus.imem_req), 16'(mFetch));
      chk("model addr", bus.imem_addr, mPc);
      chk("model instr", instr_out, mWord);
      chk("model pc2", pc_plus2_out, mP2);
      chk("model valid", 16'(instr_valid), 16'(mValid));
      chk("model halted", 16'(halted), 16'(mHalt));
      chk("model err", 16'(err), 16'(mErr));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic waitReq(string name, logic [15:0] expAddr);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({name, " timeout"}, 16'd0, 16'd1);
    chk(name, bus.imem_addr, expAddr);
  endtask

  task automatic waitValid(string name, logic [15:0] expI,
                           logic [15:0] expP2);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({name, " timeout"}, 16'd0, 16'd1);
    chk({name, " instr"}, instr_out, expI);
    chk({name, " pc2"}, pc_plus2_out, expP2);
  endtask

  task automatic fillMem(int haltOdds);
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'd0) w[15] = 1'b1;
      if (haltOdds > 0 && $urandom_range(0, haltOdds - 1) == 0)
        w[15:11] = 5'd0;
      mem[i] = w;
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_in = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    fillMem(0);
    mem[0] = 16'hC001;
    mem[1] = 16'hC102;
    mem[16'h0040] = 16'hC0AA;
    mem[16'h0041] = 16'h0000;
    mem[16'h7FFF] = 16'hC0FF;
    repeat (2) @(posedge clk);
    step();
    modelOn = 1'b1;
    chk("rst instr", instr_out, 16'h0800);
    chk("rst pc2", pc_plus2_out, 16'h0000);
    chk("rst valid", 16'(instr_valid), 16'd0);
    chk("rst req", 16'(bus.imem_req), 16'd0);
    chk("rst halted", 16'(halted), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    rst = 1'b0;

    waitReq("addr0", 16'h0000);
    waitValid("w0", 16'hC001, 16'h0002);
    step();
    chk("pulse valid", 16'(instr_valid), 16'd0);
    waitReq("addr2", 16'h0002);
    waitValid("w1", 16'hC102, 16'h0004);

    stall_in = 1'b1;
    repeat (3) begin
      step();
      chk("stall valid", 16'(instr_valid), 16'd1);
      chk("stall instr", instr_out, 16'hC102);
      chk("stall req", 16'(bus.imem_req), 16'd0);
    end
    memLat = 2;
    stall_in = 1'b0;
    waitReq("addr4", 16'h0004);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    memLat = 0;
    step();
    redirect_valid = 1'b0;
    for (int n = 0; n < 10 && !bus.imem_req; n++) begin
      chk("drain valid", 16'(instr_valid), 16'd0);
      step();
    end
    chk("drain req", 16'(bus.imem_req), 16'd1);
    chk("drain addr", bus.imem_addr, 16'h0040);

    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    step();
    redirect_valid = 1'b0;
    chk("same valid", 16'(instr_valid), 16'd0);
    waitReq("same addr", 16'h0080);
    waitValid("w80", 16'hC0AA, 16'h0082);
    step();
    waitValid("halt", 16'h0000, 16'h0084);
    chk("halt flag", 16'(halted), 16'd1);
    stall_in = 1'b1;
    step();
    chk("halt hold", 16'(instr_valid), 16'd1);
    stall_in = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    step();
    chk("halt consumed", 16'(instr_valid), 16'd0);
    chk("halt nop", instr_out, 16'h0800);
    repeat (3) begin
      step();
      chk("halt req", 16'(bus.imem_req), 16'd0);
      chk("halt addr", bus.imem_addr, 16'h0084);
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("unhalt", 16'(halted), 16'd0);
    chk("unhalt addr", bus.imem_addr, 16'h0000);

    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    waitReq("addrFFFE", 16'hFFFE);
    waitValid("wrap", 16'hC0FF, 16'h0000);
    step();
    waitReq("wrap addr", 16'h0000);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0011;
    step();
    redirect_valid = 1'b0;
    chk("odd err", 16'(err), 16'd1);
    waitReq("odd addr", 16'h0010);
    repeat (4) step();
    chk("err sticky", 16'(err), 16'd1);

    rst = 1'b1;
    fillMem(100);
    memLat = -1;
    errOn = 1'b1;
    step();
    for (int c = 0; c < 4000; c++) begin
      rst = (halted && $urandom_range(0, 7) == 0)
            || $urandom_range(0, 299) == 0;
      stall_in = $urandom_range(0, 2) == 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 7) != 0) redirect_pc[0] = 1'b0;
      if ($urandom_range(0, 15) == 0) redirect_pc = 16'hFFFE;
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
